// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: parametrised control-word pipeline (ID/EX .. MEM/WB).
// Each stage carries a control word and a valid bit. The chain supports a
// global hold, a hazard stall that inserts a bubble, and a branch flush of
// the youngest stages. Two saturating counters record bubbles and kills.
module ctrl_pipe_chain #(
  parameter int                WIDTH       = 16,
  parameter int                STAGES      = 3,
  parameter int                FLUSH_DEPTH = 1,
  parameter logic [WIDTH-1:0]  NOP_VALUE   = '0,
  parameter int                CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      R,
  input  logic [WIDTH-1:0]          in_ctrl,
  input  logic                      in_valid,
  input  logic                      hold,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      in_ready,
  output logic [STAGES*WIDTH-1:0]   stage_ctrl,
  output logic [STAGES-1:0]         stage_valid,
  output logic [CNT_W-1:0]          bubble_count,
  output logic [CNT_W-1:0]          flush_count
);

  // Reject chain shapes the shifting and kill logic was not built for.
  generate
    if (STAGES < 2 || STAGES > 8) begin : g_badStages
      $error("ctrl_pipe_chain: STAGES must be in 2..8");
    end
    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > STAGES) begin : g_badFlushDepth
      $error("ctrl_pipe_chain: FLUSH_DEPTH must be in 1..STAGES");
    end
  endgenerate

  // Sum of counter and kill count is computed 4 bits wider so that an
  // overflow past all-ones is visible and can be clamped.
  localparam logic [CNT_W+3:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] r_stage [STAGES];
  logic [STAGES-1:0] r_valid;
  logic [CNT_W-1:0]  r_bubbleCnt;
  logic [CNT_W-1:0]  r_flushCnt;

  logic [WIDTH-1:0] w_nextStage [STAGES];
  logic [STAGES-1:0] w_nextValid;
  logic [CNT_W-1:0]  w_nextBubble;
  logic [CNT_W-1:0]  w_nextFlush;
  logic [3:0]        w_killed;
  logic [CNT_W+3:0]  w_flushSum;

  // Upstream may only advance when the ID stage word is actually consumed.
  assign in_ready = ~hold & ~stall & ~R;

  // Next-state selection: hold freezes everything; otherwise shift, then
  // let flush kill the youngest stages or stall replace stage 0 by a bubble.
  always_comb begin
    w_nextStage  = r_stage;
    w_nextValid  = r_valid;
    w_nextBubble = r_bubbleCnt;
    w_nextFlush  = r_flushCnt;
    w_killed     = 4'd0;
    w_flushSum   = '0;
    if (!hold) begin
      for (int i = 1; i < STAGES; i++) begin
        w_nextStage[i] = r_stage[i-1];
        w_nextValid[i] = r_valid[i-1];
      end
      w_nextStage[0] = in_valid ? in_ctrl : NOP_VALUE;
      w_nextValid[0] = in_valid;
      if (flush) begin
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
          w_nextStage[i] = NOP_VALUE;
          w_nextValid[i] = 1'b0;
        end
        w_killed = {3'b000, in_valid};
        for (int i = 0; i < FLUSH_DEPTH - 1; i++) begin
          w_killed = w_killed + {3'b000, r_valid[i]};
        end
        w_flushSum  = {4'b0000, r_flushCnt} + {{CNT_W{1'b0}}, w_killed};
        w_nextFlush = (w_flushSum > CNT_MAX) ? {CNT_W{1'b1}} : w_flushSum[CNT_W-1:0];
      end else if (stall) begin
        w_nextStage[0] = NOP_VALUE;
        w_nextValid[0] = 1'b0;
        if (in_valid && (r_bubbleCnt != {CNT_W{1'b1}})) begin
          w_nextBubble = r_bubbleCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Pipeline and counter registers; reset empties the chain immediately.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= NOP_VALUE;
      end
      r_valid     <= '0;
      r_bubbleCnt <= '0;
      r_flushCnt  <= '0;
    end else begin
      r_stage     <= w_nextStage;
      r_valid     <= w_nextValid;
      r_bubbleCnt <= w_nextBubble;
      r_flushCnt  <= w_nextFlush;
    end
  end

  // Flatten the stage words onto the output bus, stage i at slot i.
  always_comb begin
    stage_ctrl = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_ctrl[i*WIDTH +: WIDTH] = r_stage[i];
    end
  end

  assign stage_valid  = r_valid;
  assign bubble_count = r_bubbleCnt;
  assign flush_count  = r_flushCnt;

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
- Parametrised replacement for the fixed ID_EX / EX_MEM / MEM_WB control-register chain.
- Carries one WIDTH-bit control word per stage through STAGES pipeline registers, with a per-stage valid bit.
- Adds what the fixed chain lacks: global hold (memory wait), hazard stall with bubble insertion (replaces the CU mux S=1 path), branch flush of the younger stages, and saturating bubble/flush counters for debug.
- Sits between the Control Unit output and the datapath stage consumers.

Parameters:
WIDTH, 16, bits of control word per stage
STAGES, 3, number of pipeline registers (stage 0 = ID/EX, last = MEM/WB); legal 2..8
FLUSH_DEPTH, 1, number of youngest stages (0..FLUSH_DEPTH-1) killed by flush; legal 1..STAGES
NOP_VALUE, 0, control word loaded into a killed or bubbled stage
CNT_W, 8, width of the debug counters

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
R  in  1  asynchronous active-high reset
in_ctrl  in  WIDTH  control word from the Control Unit (ID stage)
in_valid  in  1  in_ctrl holds a real instruction
hold  in  1  freeze every stage (memory wait)
stall  in  1  ID hazard: do not accept in_ctrl; insert a bubble into stage 0
flush  in  1  taken branch: kill in_ctrl and stages younger than FLUSH_DEPTH
in_ready  out  1  upstream may advance (drives IF_ID / PC load enable)
stage_ctrl  out  STAGES*WIDTH  flattened stage words; stage i at bits [i*WIDTH +: WIDTH]
stage_valid  out  STAGES  valid bit per stage
bubble_count  out  CNT_W  saturating count of stall bubbles inserted
flush_count  out  CNT_W  saturating count of valid stage entries killed by flush

Behaviour:
- Reset: R high asynchronously sets every stage_ctrl word to NOP_VALUE and every stage_valid bit to 0, and clears both counters. Reset takes effect mid-operation with no edge required.
- in_ready = ~hold & ~stall & ~R. Combinational; no latency.
- Priority at each edge is R > hold > flush > stall > normal.
- Normal: next[0] = in_ctrl and next_valid[0] = in_valid. next[i] = cur[i-1] for i >= 1. The last stage's old contents retire. Latency is 1 cycle per stage; in_ctrl appears on stage STAGES-1 after STAGES edges.
  - When in_valid = 0, stage 0 loads NOP_VALUE with valid 0, regardless of in_ctrl.
- hold: all stages and both counters keep their values. stall and flush are ignored that cycle. A flush asserted during hold is lost; the requester must keep it asserted.
- flush (hold low): the chain shifts as in normal mode, then:
  - next[i] = NOP_VALUE and next_valid[i] = 0 for all i < FLUSH_DEPTH. in_ctrl is discarded.
  - Stages i >= FLUSH_DEPTH take cur[i-1].
  - flush_count += number of valid entries killed: in_valid plus cur_valid[0..FLUSH_DEPTH-2]. Saturates at 2^CNT_W-1.
  - flush overrides a simultaneous stall; bubble_count does not change.
- stall (no hold, no flush): stage 0 loads NOP_VALUE with valid 0, and stages 1.. shift normally. in_ctrl is not consumed (upstream sees in_ready = 0). bubble_count increments only if in_valid = 1, and saturates.
- Stage words of invalid stages always equal NOP_VALUE, so consumers may ignore stage_valid.
- Counter saturation: at all ones, a counter holds its value and does not wrap.
- Parameter checks: an illegal STAGES or FLUSH_DEPTH must be caught at elaboration with an error.

Test Plan:
(All scenarios use WIDTH=16, STAGES=3, FLUSH_DEPTH=1, NOP_VALUE=0, CNT_W=8.)
1. Reset/flow: hold R=1 for 3 cycles, then release. Feed valid words 0x1111, 0x2222, 0x3333 on consecutive edges.
   -> During reset, all outputs are 0 and in_ready=0.
   -> After the 3rd edge, stage_ctrl = {0x1111, 0x2222, 0x3333} (stage2..stage0) and stage_valid = 3'b111.
2. Stall: with stages holding A, B, C, assert stall for 2 cycles with in_valid=1 and in_ctrl=0x4444.
   -> in_ready=0 for both cycles.
   -> Stage 0 reads 0 (invalid) for 2 cycles and bubble_count=2.
   -> After stall drops, 0x4444 enters stage 0 on the next edge.
3. Hold vs stall/flush: assert hold together with stall and flush for 3 cycles.
   -> stage_ctrl, stage_valid and both counters are unchanged.
   -> On release, with flush still asserted, stage 0 is killed and flush_count=1.
4. Flush depth: rebuild with FLUSH_DEPTH=2, fill stages with valid X, Y, Z, and pulse flush with in_valid=1.
   -> Stages 0 and 1 become 0 (invalid); stage 2 = the former stage-1 word.
   -> flush_count=2.
5. Saturation: apply 300 stall cycles with in_valid=1.
   -> bubble_count stops at 255 and does not wrap.
   -> Then assert R mid-stall without a clock edge: bubble_count=0 immediately.
6. Invalid input: in_valid=0 with in_ctrl=0xFFFF for one cycle.
   -> Stage 0 = 0x0000 (invalid); no counter change.
